multu_unit: RTL

MULTU_UNIT -- requirements
Module: multu_unit

---
 rtl/multu_unit_pkg.sv | 20 ++
 rtl/multu_unit_if.sv | 24 ++
 rtl/multu_unit_hilo.sv | 38 +++
 rtl/multu_unit.sv | 92 +++++++++
 4 files changed

// File: rtl/multu_unit_pkg.sv
// Shared CPU definitions for the iterative unsigned multiplier: FSM encoding,
// operand width, iteration count and the multiplier op codes used by ALU control.
package multu_unit_pkg;

  localparam int MULTU_W     = 32;
  localparam int MULTU_ITERS = MULTU_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } multu_state_e;

  typedef enum logic [5:0] {
    OP_MULT     = 6'b011001,
    OP_MADDU    = 6'b000001,
    OP_FINISHED = 6'b111111
  } multu_op_e;

endpackage

// File: rtl/multu_unit_if.sv
// Request/response bundle between the ALU control stage (master) and the
// multiplier (slave); HI/LO are exposed here for mfhi/mflo.
interface multu_unit_if #(
   parameter int W = multu_unit_pkg::MULTU_W
);
   logic         start;
   logic         add;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   modport master (
      output start, add, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, add, a, b,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/multu_unit_hilo.sv
// HI/LO architectural registers with the 2W-bit accumulate adder used by maddu.
// The final carry out of the accumulate is dropped, so maddu wraps silently.
module multu_hilo #(
   parameter int W = multu_unit_pkg::MULTU_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en_i,
   input  logic           add_i,
   input  logic [2*W-1:0] p_i,
   output logic [W-1:0]   hi_o,
   output logic [W-1:0]   lo_o
);

   logic [2*W-1:0] hilo_q;
   logic [2*W-1:0] hilo_d;

   // NOTE: combinational blocks assign every output on every path so no latch is inferred.
   always_comb begin
      hilo_d = hilo_q;
      if (wr_en_i) begin
         hilo_d = add_i ? (hilo_q + p_i) : p_i;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hilo_q <= '0;
      end else begin
         hilo_q <= hilo_d;
      end
   end

   assign hi_o = hilo_q[2*W-1:W];
   assign lo_o = hilo_q[W-1:0];

endmodule

// File: rtl/multu_unit.sv
// Iterative W x W unsigned multiplier (multu/maddu): one shift-add step per RUN
// cycle, result committed to HI/LO when leaving DONE, one-cycle done pulse after.
module multu_unit
   import multu_unit_pkg::*;
#(
   parameter int W = MULTU_W
) (
   input  logic         clk,
   input  logic         rst_n,
   multu_unit_if.slave  bus
);

   localparam int             CW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0]  LAST = CW'(W - 1);

   multu_state_e    state_q;
   logic [2*W-1:0]  p_q;
   logic [W-1:0]    a_q;
   logic            add_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;

   logic [W:0]      sum_d;
   logic [2*W-1:0]  p_d;
   logic            hilo_wr;

   // Upper half plus multiplicand keeps its carry, which shifts back in at the top.
   always_comb begin
      sum_d = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : '0);
      p_d   = {sum_d, p_q[W-1:1]};
   end

   assign hilo_wr = (state_q == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         p_q     <= '0;
         a_q     <= '0;
         add_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  add_q   <= bus.add;
                  p_q     <= {{W{1'b0}}, bus.b};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               p_q <= p_d;
               if (cnt_q == LAST) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   multu_hilo #(.W(W)) u_hilo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en_i (hilo_wr),
      .add_i   (add_q),
      .p_i     (p_q),
      .hi_o    (bus.hi),
      .lo_o    (bus.lo)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
